// File: rtl/stall_mem_resp.sv
// Multi-cycle 16-bit data-memory responder: one request at a time, done pulse after LATENCY cycles.
// Optional STALL_MEM_ALIGN_CHECK_EN: an odd byte address at accept is flagged as an error.
module stall_mem_resp #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, state_d;
    logic [3:0]  count, count_d;

    logic          wr_q;
    logic [AW-1:0] idx_q;
    logic [15:0]   wdata_q;
    logic          err_q;

    logic          accept;
    logic          req_err;
    logic          range_err;
    logic          commit;
    logic          c_wr;
    logic [AW-1:0] c_idx;
    logic [15:0]   c_wdata;
    logic          c_err;

    // Storage is deliberately left out of reset; it starts at zero.
    logic [15:0] mem [MEM_WORDS] = '{default: 16'h0000};

    // BUSY always carries a non-zero count, so the done cycle is already IDLE.
    assign stall  = (state == BUSY);
    assign accept = enable && !stall;

    assign range_err = ({17'b0, addr[15:1]} >= 32'(MEM_WORDS));

`ifdef STALL_MEM_ALIGN_CHECK_EN
    assign req_err = range_err || addr[0];
`else
    logic unused_bits;
    assign unused_bits = addr[0];
    assign req_err     = range_err;
`endif

    always_comb begin
        state_d = state;
        count_d = count;
        commit  = 1'b0;
        c_wr    = wr_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        c_err   = err_q;

        case (state)
            IDLE: ;
            BUSY: begin
                if (count == 4'd1) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                    count_d = 4'd0;
                end else begin
                    count_d = count - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A single-cycle responder commits straight from the request inputs.
        if (accept) begin
            if (LATENCY == 1) begin
                commit  = 1'b1;
                c_wr    = wr;
                c_idx   = addr[AW:1];
                c_wdata = data_in;
                c_err   = req_err;
            end else begin
                state_d = BUSY;
                count_d = 4'(LATENCY - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_d;
            count <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else if (accept) begin
            wr_q    <= wr;
            idx_q   <= addr[AW:1];
            wdata_q <= data_in;
            err_q   <= req_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            err      <= 1'b0;
            data_out <= 16'h0000;
        end else begin
            done <= commit;
            err  <= commit && c_err;
            if (commit && !c_wr) begin
                data_out <= c_err ? 16'h0000 : mem[c_idx];
            end
        end
    end

    // An erroneous write never touches the array; rst blocks any commit.
    always_ff @(posedge clk) begin
        if (!rst && commit && c_wr && !c_err) begin
            mem[c_idx] <= c_wdata;
        end
    end

endmodule
